// File: rtl/roulette_pkg.sv
// Shared definitions for the roulette round controller: state encodings,
// bet-mode constants, default money constants and the win judgement helper.
package roulette_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BET = 3'd1,
        ST_SPIN     = 3'd2,
        ST_EVAL     = 3'd3,
        ST_CHECK    = 3'd4,
        ST_WON      = 3'd5,
        ST_LOST     = 3'd6,
        ST_UNUSED   = 3'd7
    } state_e;

    localparam logic BET_EXACT  = 1'b0;
    localparam logic BET_PARITY = 1'b1;

    localparam logic [4:0] START_BAL  = 5'd10;
    localparam logic [4:0] WIN_EXACT  = 5'd4;
    localparam logic [4:0] WIN_PARITY = 5'd1;
    localparam logic [4:0] LOSE_AMT   = 5'd1;
    localparam logic [4:0] WIN_LIMIT  = 5'd20;

    // Exact bets need the whole number, parity bets only bit 0 (0 even, 1 odd).
    function automatic logic bet_wins(input logic mode, input logic [4:0] guess,
                                      input logic [4:0] num);
        logic win;
        if (mode == BET_PARITY) begin
            win = (guess[0] == num[0]);
        end else begin
            win = (guess == num);
        end
        return win;
    endfunction

endpackage

// File: rtl/roulette_round_ctrl_if.sv
// Player-side bus of the roulette round controller: bet inputs from the
// board switches/keys and status outputs towards the HEX/LED drivers.
interface roulette_round_ctrl_if;
    logic       start_btn;
    logic       bet_mode;
    logic [4:0] player_guess;
    logic [4:0] balance;
    logic [4:0] spin_num;
    logic [2:0] state_out;
    logic       led_win;
    logic       led_lose;
    logic       round_done;
    logic       bet_err;
    logic       busy;

    modport master (
        output start_btn, bet_mode, player_guess,
        input  balance, spin_num, state_out, led_win, led_lose,
               round_done, bet_err, busy
    );

    modport slave (
        input  start_btn, bet_mode, player_guess,
        output balance, spin_num, state_out, led_win, led_lose,
               round_done, bet_err, busy
    );
endinterface

// File: rtl/roulette_lfsr.sv
// 5-bit Fibonacci LFSR, polynomial x^5+x^3+1, seed 1, free-running.
// Maximal length (31 states), never reaches zero. Shared with the blackjack draw.
module roulette_lfsr (
    input  logic       Clock,
    input  logic       reset,
    output logic [4:0] lfsr_out
);

    logic [4:0] lfsr_q;
    logic [4:0] lfsr_d;

    // Next value: shift left, feed back taps 5 and 3.
    always_comb begin
        lfsr_d = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    end

    // LFSR register, seeded with 1 so it never locks up at zero.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= 5'b00001;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_out = lfsr_q;

endmodule

// File: rtl/roulette_round_ctrl.sv
// Roulette round sequencer: latches a bet on a start-button rising edge,
// spins the LFSR for SPIN_CYCLES clocks, judges the bet, updates the
// balance and decides between next round, game won and game lost.
// Optional build macro ROULETTE_FLASH_EN: LEDs blink every FLASH_DIV clocks
// in WON/LOST instead of staying steady.
module roulette_round_ctrl
    import roulette_pkg::*;
#(
    parameter int SPIN_CYCLES = 8
`ifdef ROULETTE_FLASH_EN
    , parameter int FLASH_DIV = 12500000
`endif
) (
    input  logic                  Clock,
    input  logic                  reset,
    roulette_round_ctrl_if.slave  bus
);

    localparam int CW = (SPIN_CYCLES > 1) ? $clog2(SPIN_CYCLES) : 1;
    localparam logic [CW-1:0] SPIN_LAST = CW'(SPIN_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_e        state_q, state_d;
    logic [4:0]    balance_q, balance_d;
    logic [4:0]    spin_num_q, spin_num_d;
    logic [CW-1:0] spin_cnt_q, spin_cnt_d;
    logic          mode_q, mode_d;
    logic [4:0]    guess_q, guess_d;
    logic          start_prev_q;
    logic          bet_err_q, bet_err_d;
    logic          round_done_q, round_done_d;
    logic          busy_q, busy_d;
    logic          led_win_q, led_win_d;
    logic          led_lose_q, led_lose_d;
    logic          start_edge_s;
    logic          led_on_s;
    logic          win_s;
    logic [4:0]    credit_s;
    logic [4:0]    lfsr_s;

    roulette_lfsr u_lfsr (
        .Clock    (Clock),
        .reset    (reset),
        .lfsr_out (lfsr_s)
    );

    assign start_edge_s = bus.start_btn & ~start_prev_q;
    assign win_s        = bet_wins(mode_q, guess_q, spin_num_q);
    assign credit_s     = (mode_q == BET_PARITY) ? WIN_PARITY : WIN_EXACT;

    // Next-state, bet latching, balance update and registered-output preparation.
    always_comb begin
        state_d      = state_q;
        balance_d    = balance_q;
        spin_num_d   = spin_num_q;
        spin_cnt_d   = spin_cnt_q;
        mode_d       = mode_q;
        guess_d      = guess_q;
        bet_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                balance_d = START_BAL;
                state_d   = ST_WAIT_BET;
            end
            ST_WAIT_BET: begin
                if (start_edge_s) begin
                    mode_d  = bus.bet_mode;
                    guess_d = bus.player_guess;
                    if ((bus.bet_mode == BET_EXACT) && (bus.player_guess == 5'd0)) begin
                        bet_err_d = 1'b1;
                    end else begin
                        state_d    = ST_SPIN;
                        spin_cnt_d = '0;
                    end
                end else begin
                    state_d = ST_WAIT_BET;
                end
            end
            ST_SPIN: begin
                if (spin_cnt_q == SPIN_LAST) begin
                    spin_num_d = lfsr_s;
                    state_d    = ST_EVAL;
                end else begin
                    spin_cnt_d = spin_cnt_q + CNT_ONE;
                end
            end
            ST_EVAL: begin
                if (win_s) begin
                    balance_d = balance_q + credit_s;
                end else if (balance_q > LOSE_AMT) begin
                    balance_d = balance_q - LOSE_AMT;
                end else begin
                    balance_d = 5'd0;
                end
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (balance_q > WIN_LIMIT) begin
                    state_d = ST_WON;
                end else if (balance_q == 5'd0) begin
                    state_d = ST_LOST;
                end else begin
                    state_d = ST_WAIT_BET;
                end
            end
            ST_WON, ST_LOST: begin
                if (start_edge_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        round_done_d = (state_d == ST_CHECK);
        busy_d       = (state_d == ST_SPIN) || (state_d == ST_EVAL) || (state_d == ST_CHECK);
        led_win_d    = (state_d == ST_WON) & led_on_s;
        led_lose_d   = (state_d == ST_LOST) & led_on_s;
    end

`ifdef ROULETTE_FLASH_EN
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);
    localparam logic [FW-1:0] FLASH_ONE  = FW'(1);

    logic [FW-1:0] flash_cnt_q, flash_cnt_d;
    logic          phase_q, phase_d;
    logic          end_state_d_s;

    assign end_state_d_s = (state_d == ST_WON) || (state_d == ST_LOST);

    // Blink phase: restarts lit on entry to WON/LOST, toggles every FLASH_DIV clocks.
    always_comb begin
        flash_cnt_d = flash_cnt_q;
        phase_d     = phase_q;
        if (end_state_d_s && (state_d != state_q)) begin
            flash_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (end_state_d_s) begin
            if (flash_cnt_q == FLASH_LAST) begin
                flash_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                flash_cnt_d = flash_cnt_q + FLASH_ONE;
            end
        end else begin
            flash_cnt_d = '0;
            phase_d     = 1'b1;
        end
        led_on_s = phase_d;
    end

    // Blink counter and phase registers.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            flash_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            flash_cnt_q <= flash_cnt_d;
            phase_q     <= phase_d;
        end
    end
`else
    assign led_on_s = 1'b1;
`endif

    // State, datapath and registered outputs.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            balance_q    <= START_BAL;
            spin_num_q   <= 5'd0;
            spin_cnt_q   <= '0;
            mode_q       <= BET_EXACT;
            guess_q      <= 5'd0;
            start_prev_q <= 1'b0;
            bet_err_q    <= 1'b0;
            round_done_q <= 1'b0;
            busy_q       <= 1'b0;
            led_win_q    <= 1'b0;
            led_lose_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            balance_q    <= balance_d;
            spin_num_q   <= spin_num_d;
            spin_cnt_q   <= spin_cnt_d;
            mode_q       <= mode_d;
            guess_q      <= guess_d;
            start_prev_q <= bus.start_btn;
            bet_err_q    <= bet_err_d;
            round_done_q <= round_done_d;
            busy_q       <= busy_d;
            led_win_q    <= led_win_d;
            led_lose_q   <= led_lose_d;
        end
    end

    assign bus.balance    = balance_q;
    assign bus.spin_num   = spin_num_q;
    assign bus.state_out  = state_q;
    assign bus.led_win    = led_win_q;
    assign bus.led_lose   = led_lose_q;
    assign bus.round_done = round_done_q;
    assign bus.bet_err    = bet_err_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_roulette_round_ctrl.sv
// Directed self-checking bench for roulette_round_ctrl (default build).
module tb_roulette_round_ctrl;

    localparam int SPIN_CYCLES = 8;

    logic Clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   rd_cnt = 0;
    logic [4:0] model_lfsr;
    logic [4:0] pred;
    logic [4:0] g;
    int   rd0;

    always #5 Clock = ~Clock;

    roulette_round_ctrl_if bus ();

    roulette_round_ctrl dut (
        .Clock (Clock),
        .reset (reset),
        .bus   (bus)
    );

    // Reference x^5+x^3+1 sequence, seeded 1, advancing every clock.
    always @(posedge Clock or posedge reset) begin
        if (reset) model_lfsr <= 5'd1;
        else       model_lfsr <= {model_lfsr[3:0], model_lfsr[4] ^ model_lfsr[2]};
    end

    // Counts round_done pulses, sampled on the falling edge.
    always @(negedge Clock) begin
        if (bus.round_done === 1'b1) rd_cnt++;
    end

    function automatic logic [4:0] adv(input logic [4:0] v, input int n);
        logic [4:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[3:0], r[4] ^ r[2]};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // One complete round from the accepting edge to the state after CHECK.
    task automatic run_round(input string tag, input logic mode, input logic [4:0] guess,
                             input logic [4:0] p, input logic [4:0] exp_bal,
                             input logic [2:0] exp_state);
        int n;
        bus.bet_mode     = mode;
        bus.player_guess = guess;
        bus.start_btn    = 1'b1;
        tick(1);
        bus.start_btn    = 1'b0;
        chk({tag, "_spin_state"}, 32'(bus.state_out), 32'd2);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (bus.round_done !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        // Clocks from the accepting edge (inclusive) to round_done visible.
        chk({tag, "_latency"}, 32'(n + 1), 32'(SPIN_CYCLES + 2));
        chk({tag, "_spin_num"}, 32'(bus.spin_num), 32'(p));
        chk({tag, "_balance"}, 32'(bus.balance), 32'(exp_bal));
        tick(1);
        chk({tag, "_next_state"}, 32'(bus.state_out), 32'(exp_state));
        chk({tag, "_rd_clear"}, 32'(bus.round_done), 32'd0);
    endtask

    initial begin
        reset            = 1'b1;
        bus.start_btn    = 1'b0;
        bus.bet_mode     = 1'b0;
        bus.player_guess = 5'd0;
        tick(2);
        chk("rst_state", 32'(bus.state_out), 32'd0);
        chk("rst_balance", 32'(bus.balance), 32'd10);
        chk("rst_spin", 32'(bus.spin_num), 32'd0);
        chk("rst_leds", 32'({bus.led_win, bus.led_lose}), 32'd0);
        chk("rst_pulses", 32'({bus.round_done, bus.bet_err, bus.busy}), 32'd0);
        reset = 1'b0;
        tick(3);
        chk("idle_state", 32'(bus.state_out), 32'd1);
        chk("idle_balance", 32'(bus.balance), 32'd10);
        chk("idle_spin", 32'(bus.spin_num), 32'd0);
        chk("idle_leds", 32'({bus.led_win, bus.led_lose}), 32'd0);

        // Exact bet on 0 is rejected.
        bus.bet_mode = 1'b0; bus.player_guess = 5'd0; bus.start_btn = 1'b1;
        tick(1);
        bus.start_btn = 1'b0;
        chk("err_pulse", 32'(bus.bet_err), 32'd1);
        chk("err_state", 32'(bus.state_out), 32'd1);
        tick(1);
        chk("err_pulse_end", 32'(bus.bet_err), 32'd0);
        chk("err_state2", 32'(bus.state_out), 32'd1);
        chk("err_balance", 32'(bus.balance), 32'd10);

        // Parity win then parity loss.
        pred = adv(model_lfsr, SPIN_CYCLES);
        run_round("par_win", 1'b1, {4'b0000, pred[0]}, pred, 5'd11, 3'd1);
        pred = adv(model_lfsr, SPIN_CYCLES);
        run_round("par_loss", 1'b1, {4'b0000, ~pred[0]}, pred, 5'd10, 3'd1);

        // Three exact wins: 14, 18, 22 -> WON.
        pred = adv(model_lfsr, SPIN_CYCLES);
        run_round("ex_win1", 1'b0, pred, pred, 5'd14, 3'd1);
        pred = adv(model_lfsr, SPIN_CYCLES);
        run_round("ex_win2", 1'b0, pred, pred, 5'd18, 3'd1);
        pred = adv(model_lfsr, SPIN_CYCLES);
        run_round("ex_win3", 1'b0, pred, pred, 5'd22, 3'd5);
        chk("won_led_win", 32'(bus.led_win), 32'd1);
        chk("won_led_lose", 32'(bus.led_lose), 32'd0);
        chk("won_busy", 32'(bus.busy), 32'd0);
        tick(3);
        chk("won_hold_state", 32'(bus.state_out), 32'd5);
        chk("won_led_steady", 32'(bus.led_win), 32'd1);

        // New game from WON.
        bus.start_btn = 1'b1;
        tick(1);
        bus.start_btn = 1'b0;
        chk("won_restart_idle", 32'(bus.state_out), 32'd0);
        chk("won_restart_led", 32'(bus.led_win), 32'd0);
        tick(1);
        chk("won_restart_wait", 32'(bus.state_out), 32'd1);
        chk("won_restart_bal", 32'(bus.balance), 32'd10);

        // Ten exact losses: 9..0 -> LOST.
        for (int i = 0; i < 10; i++) begin
            pred = adv(model_lfsr, SPIN_CYCLES);
            g = (pred == 5'd31) ? 5'd1 : pred + 5'd1;
            run_round("ex_loss", 1'b0, g, pred, 5'(9 - i), (i == 9) ? 3'd6 : 3'd1);
        end
        chk("lost_led_lose", 32'(bus.led_lose), 32'd1);
        chk("lost_led_win", 32'(bus.led_win), 32'd0);
        bus.start_btn = 1'b1;
        tick(1);
        bus.start_btn = 1'b0;
        chk("lost_restart_idle", 32'(bus.state_out), 32'd0);
        tick(1);
        chk("lost_restart_wait", 32'(bus.state_out), 32'd1);
        chk("lost_restart_bal", 32'(bus.balance), 32'd10);

        // Start held through SPIN plus an extra rising edge mid-SPIN.
        rd0  = rd_cnt;
        pred = adv(model_lfsr, SPIN_CYCLES);
        bus.bet_mode = 1'b1; bus.player_guess = {4'b0000, ~pred[0]};
        bus.start_btn = 1'b1;
        tick(1);
        chk("held_spin", 32'(bus.state_out), 32'd2);
        tick(3);
        bus.start_btn = 1'b0;
        tick(1);
        bus.start_btn = 1'b1;
        tick(1);
        chk("held_still_spin", 32'(bus.state_out), 32'd2);
        bus.start_btn = 1'b0;
        tick(14);
        chk("held_one_round", 32'(rd_cnt - rd0), 32'd1);
        chk("held_balance", 32'(bus.balance), 32'd9);
        chk("held_state", 32'(bus.state_out), 32'd1);

        // Reset asserted during EVAL discards the round.
        pred = adv(model_lfsr, SPIN_CYCLES);
        g = (pred == 5'd31) ? 5'd1 : pred + 5'd1;
        bus.bet_mode = 1'b0; bus.player_guess = g; bus.start_btn = 1'b1;
        tick(1);
        bus.start_btn = 1'b0;
        tick(SPIN_CYCLES);
        chk("mid_eval_state", 32'(bus.state_out), 32'd3);
        rd0   = rd_cnt;
        reset = 1'b1;
        #1;
        chk("mid_rst_state", 32'(bus.state_out), 32'd0);
        chk("mid_rst_balance", 32'(bus.balance), 32'd10);
        chk("mid_rst_spin", 32'(bus.spin_num), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(2);
        chk("mid_rst_no_rd", 32'(rd_cnt - rd0), 32'd0);
        chk("mid_rst_wait", 32'(bus.state_out), 32'd1);
        chk("mid_rst_bal2", 32'(bus.balance), 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/roulette_round_ctrl.md
Name: roulette_round_ctrl

Overview:
Round sequencer for the roulette game. It detects the player's start press and latches the bet (mode plus guess). It then runs a spin on an internal LFSR, judges win or loss, and updates the player balance. It finishes each round by declaring game won, game lost or next round. It sits between the board switches/keys and the HEX/LED display drivers, and replaces ad-hoc edge-triggered game logic with one clocked FSM.

Parameters:
START_BAL, 10, balance loaded on reset and on game restart (5-bit)
WIN_EXACT, 4, credit for a correct exact-number bet
WIN_PARITY, 1, credit for a correct even/odd bet
LOSE_AMT, 1, debit for any losing bet
WIN_LIMIT, 20, game is won when balance > WIN_LIMIT
SPIN_CYCLES, 8, clocks spent in SPIN before the number is sampled (>=1)
FLASH_DIV, 12500000, clocks per LED toggle when ROULETTE_FLASH_EN is defined

Ports:
Clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start_btn  input  1  synchronous level, active-high; only rising edges act
bet_mode  input  1  0 = exact number, 1 = parity (guess[0] names parity: 0 even, 1 odd)
player_guess  input  5  guess; exact mode valid range 1..31
balance  output  5  current balance
spin_num  output  5  last spun number, 1..31
state_out  output  3  FSM state encoding, for HEX debug
led_win  output  1  win indication
led_lose  output  1  lose indication
round_done  output  1  one-cycle pulse at end of each judged round
bet_err  output  1  one-cycle pulse when a bet is rejected
busy  output  1  high in SPIN, EVAL and CHECK

Behaviour:
- Reset values: balance=START_BAL, spin_num=0, state=IDLE, all LEDs and pulses 0, LFSR=5'b00001, start_btn history reg=0.
- LFSR: 5-bit Fibonacci, polynomial x^5+x^3+1. Free-running every clock in all states. Never 0, period 31.
- Start edge: start_btn & ~start_prev, with start_prev registered.
- IDLE (0): load balance=START_BAL, clear LEDs. Go to WAIT_BET on the next clock.
- WAIT_BET (1): on a start edge, latch bet_mode and player_guess.
  - If exact mode and guess==0: pulse bet_err and stay in WAIT_BET.
  - Otherwise go to SPIN and clear the spin counter.
- SPIN (2): count SPIN_CYCLES clocks. On the last one, spin_num<=LFSR and go to EVAL.
- EVAL (3): single cycle.
  - win = (exact & guess==spin_num) | (parity & guess[0]==spin_num[0]).
  - On win: balance += credit. Max 20+4=24, so no overflow at defaults.
  - On loss: balance -= LOSE_AMT, saturating at 0.
- CHECK (4): single cycle; round_done pulses here.
  - If balance > WIN_LIMIT: go to WON.
  - Else if balance==0: go to LOST.
  - Else go to WAIT_BET.
- WON (5): led_win=1. LOST (6): led_lose=1.
  - In either state, a start edge goes to IDLE (new game).
  - Unused encoding 7 goes to IDLE.
- Start edges in SPIN, EVAL and CHECK are ignored and not queued.
- Round latency from start edge to round_done: SPIN_CYCLES+2 clocks.
- Reset asserted mid-round: immediate return to reset values. No partial balance update survives.
- Bet inputs are sampled only at the accepting edge. Changes during SPIN have no effect.

Optional Feature:
ROULETTE_FLASH_EN:
- Defined: led_win/led_lose toggle every FLASH_DIV clocks while in WON/LOST. The phase starts at 1 on entry, driven by a counter that is cleared on state entry.
- Undefined: the LEDs are steady high in WON/LOST, and no counter is synthesised.

Decomposition:
- Shared package roulette_pkg holds:
  - state encodings ST_IDLE..ST_LOST;
  - BET_EXACT/BET_PARITY constants;
  - the default money constants (START_BAL, WIN_EXACT, WIN_PARITY, LOSE_AMT, WIN_LIMIT).
- One sub-module, roulette_lfsr (Clock, reset, 5-bit out, seed 1). It is reused by the blackjack card draw.

Test Plan:
- Reset, then idle 3 clocks -> balance=10, state_out=1, spin_num=0, LEDs 0.
- Exact bet, guess=0, start edge -> bet_err pulses once, state stays 1, balance 10.
- Parity bet matching the model-predicted spin_num parity -> round_done at start+10 clocks (SPIN_CYCLES=8), balance 10->11.
- Exact bet with guess = predicted spin_num, repeated 3 times -> balance 10, 14, 18, 22 -> state WON, led_win=1 (steady without the macro, toggling with ROULETTE_FLASH_EN and FLASH_DIV=4).
- Ten consecutive losing exact bets -> balance decrements to 0 -> LOST, led_lose=1. A further start edge -> IDLE -> balance 10.
- Start held high through SPIN plus an extra pulse mid-SPIN -> only one round judged. Reset asserted during EVAL -> balance 10, state 0, no round_done.
